// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store bus master:
// access size codes, FSM state encoding, byte-enable patterns and
// the op legality check used while the master sits in IDLE.
package lsu_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // An op is legal when its size code exists and the address is
    // naturally aligned for that size.
    function automatic logic opLegal(input logic [2:0] mode, input logic [1:0] addrLo);
        logic ok;
        case (mode[2:1])
            SZ_WORD: ok = (addrLo == 2'b00);
            SZ_HALF: ok = (addrLo[0] == 1'b0);
            SZ_BYTE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Data memory bus between the load/store master and the memory slave.
// The slave completes a request in the cycle it raises bus_ready;
// bus_rdata is only meaningful in that cycle.
interface lsu_bus_master_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ready;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/lsu_lane_unit.sv
// Byte-lane datapath for the load/store master. The request side turns
// an op into byte enables plus lane-replicated store data; the load side
// picks the addressed lane out of the read word and extends it.
// Purely combinational; all state lives in the top.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [2:0]  reqMode,
    input  logic [1:0]  reqAddrLo,
    input  logic [31:0] reqWdata,
    output logic [3:0]  reqBe,
    output logic [31:0] reqLanes,
    input  logic [2:0]  ldMode,
    input  logic [1:0]  ldAddrLo,
    input  logic [31:0] rdata,
    output logic [31:0] ldExt
);

    logic [15:0] halfSel;
    logic [7:0]  byteSel;

    // Byte enables and store lanes for the op being accepted.
    always_comb begin
        reqBe    = 4'b0000;
        reqLanes = 32'h0000_0000;
        case (reqMode[2:1])
            SZ_WORD: begin
                reqBe    = BE_WORD;
                reqLanes = reqWdata;
            end
            SZ_HALF: begin
                reqBe    = reqAddrLo[1] ? BE_HALF_HI : BE_HALF_LO;
                reqLanes = {2{reqWdata[15:0]}};
            end
            SZ_BYTE: begin
                reqBe    = BE_BYTE0 << reqAddrLo;
                reqLanes = {4{reqWdata[7:0]}};
            end
            default: begin
                reqBe    = 4'b0000;
                reqLanes = 32'h0000_0000;
            end
        endcase
    end

    // Select the addressed lane of the read word and sign/zero-extend it.
    always_comb begin
        halfSel = ldAddrLo[1] ? rdata[31:16] : rdata[15:0];
        case (ldAddrLo)
            2'd0:    byteSel = rdata[7:0];
            2'd1:    byteSel = rdata[15:8];
            2'd2:    byteSel = rdata[23:16];
            2'd3:    byteSel = rdata[31:24];
            default: byteSel = 8'h00;
        endcase
        case (ldMode[2:1])
            SZ_HALF: ldExt = {{16{ldMode[0] & halfSel[15]}}, halfSel};
            SZ_BYTE: ldExt = {{24{ldMode[0] & byteSel[7]}}, byteSel};
            default: ldExt = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// MEM-stage load/store initiator for the multi-cycle data memory bus.
// Accepts one op from the pipeline, rejects misaligned/illegal ops with
// a one-cycle align_err, otherwise issues a single word-aligned bus
// request and stalls the pipeline until the slave answers (DONE cycle)
// or the request times out (bus_err cycle).
// Optional build macro LSU_TRACE_EN: prints a trace line for every
// completing store; logic is identical with or without it.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_we,
    input  logic [2:0]        op_mode,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [31:0]       op_wdata,
    input  logic [31:0]       op_pc,
    output logic              stall,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic              align_err,
    output logic              bus_err,
    lsu_bus_master_if.master  bus
);

    // Last REQ-cycle count before giving up; unused when TIMEOUT is 0.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    lsu_state_e        state;
    lsu_state_e        nextState;
    logic              busReq;
    logic              busWe;
    logic [ADDR_W-1:0] busAddr;
    logic [3:0]        busBe;
    logic [31:0]       busWdata;
    logic [31:0]       ldData;
    logic [31:0]       toCnt;
    logic [2:0]        modeR;
    logic [1:0]        addrLoR;

    logic              legal;
    logic              accept;
    logic              alignHit;
    logic              timeoutHit;
    logic [3:0]        reqBe;
    logic [31:0]       reqLanes;
    logic [31:0]       ldExt;

    // op_pc only feeds the optional trace.
    logic              unusedPc;
    assign unusedPc = ^op_pc;

    // Mode and address of the op are captured at accept so the load
    // lane can be extracted even if the pipeline drops op_valid.
    lsu_lane_unit u_lane (
        .reqMode   (op_mode),
        .reqAddrLo (op_addr[1:0]),
        .reqWdata  (op_wdata),
        .reqBe     (reqBe),
        .reqLanes  (reqLanes),
        .ldMode    (modeR),
        .ldAddrLo  (addrLoR),
        .rdata     (bus.bus_rdata),
        .ldExt     (ldExt)
    );

    // Next-state and per-cycle event decode; ready beats timeout in REQ.
    always_comb begin
        nextState  = state;
        accept     = 1'b0;
        alignHit   = 1'b0;
        timeoutHit = 1'b0;
        legal      = opLegal(op_mode, op_addr[1:0]);
        case (state)
            IDLE: begin
                if (op_valid) begin
                    if (legal) begin
                        accept    = 1'b1;
                        nextState = REQ;
                    end else begin
                        alignHit  = 1'b1;
                        nextState = IDLE;
                    end
                end else begin
                    nextState = IDLE;
                end
            end
            REQ: begin
                if (bus.bus_ready) begin
                    nextState = DONE;
                end else if ((TIMEOUT != 0) && (toCnt == TO_LAST)) begin
                    timeoutHit = 1'b1;
                    nextState  = IDLE;
                end else begin
                    nextState = REQ;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Bus request registers: loaded at accept, held through REQ, request
    // dropped on ready or timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            busReq   <= 1'b0;
            busWe    <= 1'b0;
            busAddr  <= '0;
            busBe    <= 4'b0000;
            busWdata <= 32'h0000_0000;
            modeR    <= 3'b000;
            addrLoR  <= 2'b00;
        end else if (accept) begin
            busReq   <= 1'b1;
            busWe    <= op_we;
            busAddr  <= {op_addr[ADDR_W-1:2], 2'b00};
            busBe    <= reqBe;
            busWdata <= op_we ? reqLanes : 32'h0000_0000;
            modeR    <= op_mode;
            addrLoR  <= op_addr[1:0];
        end else if (state == REQ && (bus.bus_ready || timeoutHit)) begin
            busReq   <= 1'b0;
        end
    end

    // Wait-cycle counter: counts REQ cycles without ready, cleared on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            toCnt <= 32'd0;
        end else if (accept) begin
            toCnt <= 32'd0;
        end else if (state == REQ && !bus.bus_ready) begin
            toCnt <= timeoutHit ? 32'd0 : toCnt + 32'd1;
        end
    end

    // Load result register, captured when the slave returns the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            ldData <= 32'h0000_0000;
        end else if (state == REQ && bus.bus_ready && !busWe) begin
            ldData <= ldExt;
        end
    end

`ifdef LSU_TRACE_EN
    // Trace every store as the slave accepts it.
    always_ff @(posedge clk) begin
        if (!reset && state == REQ && bus.bus_ready && busWe) begin
            $display("%d@%08h: *%08h <= %08h be=%b", $time, op_pc, busAddr, busWdata, busBe);
        end
    end
`endif

    assign bus.bus_req   = busReq;
    assign bus.bus_we    = busWe;
    assign bus.bus_addr  = busAddr;
    assign bus.bus_be    = busBe;
    assign bus.bus_wdata = busWdata;

    assign ld_data   = ldData;
    assign ld_valid  = !reset && (state == DONE) && !busWe;
    assign align_err = !reset && alignHit;
    assign bus_err   = !reset && timeoutHit;
    assign stall     = op_valid && legal && (state != DONE) && !timeoutHit;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed ops from the block's use cases
// followed by randomized ops, all checked every cycle against a
// transaction-level model of the master's externally visible behaviour.
module tb_lsu_bus_master;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic        op_we;
    logic [2:0]  op_mode;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [31:0] op_pc;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        align_err;
    logic        bus_err;

    lsu_bus_master_if #(.ADDR_W(32)) bus ();

    lsu_bus_master #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_we     (op_we),
        .op_mode   (op_mode),
        .op_addr   (op_addr),
        .op_wdata  (op_wdata),
        .op_pc     (op_pc),
        .stall     (stall),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .align_err (align_err),
        .bus_err   (bus_err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for the current cycle, set by the stimulus.
    logic        chkEn, busChk;
    logic        eStall, eAlign, eBerr, eReq, eLdv, eWe;
    logic [31:0] eLd, eAddr, eWdata;
    logic [3:0]  eBe;
    // Hand-computed pins for the directed ops.
    logic        pinBusEn, pinLdEn;
    logic [31:0] pinAddr, pinWdata, pinLd;
    logic [3:0]  pinBe;
    int          pinLdT;

    int nChecks = 0;
    int nErr    = 0;
    int cycleCnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cycleCnt, act, exp);
        end
    endtask

    // Compare process: sample outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (chkEn) begin
            check("stall", 32'(stall), 32'(eStall));
            check("align_err", 32'(align_err), 32'(eAlign));
            check("bus_err", 32'(bus_err), 32'(eBerr));
            check("ld_valid", 32'(ld_valid), 32'(eLdv));
            check("ld_data", ld_data, eLd);
            check("bus_req", 32'(bus.bus_req), 32'(eReq));
            if (busChk) begin
                check("bus_addr", bus.bus_addr, eAddr);
                check("bus_be", 32'(bus.bus_be), 32'(eBe));
                check("bus_we", 32'(bus.bus_we), 32'(eWe));
                check("bus_wdata", bus.bus_wdata, eWdata);
            end
            if (pinBusEn && bus.bus_req) begin
                check("pin_addr", bus.bus_addr, pinAddr);
                check("pin_be", 32'(bus.bus_be), 32'(pinBe));
                check("pin_wdata", bus.bus_wdata, pinWdata);
            end
            if (pinLdEn && ld_valid) begin
                check("pin_ld_data", ld_data, pinLd);
                check("pin_ld_time", 32'(cycleCnt), 32'(pinLdT));
            end
        end
        cycleCnt++;
    end

    // ---------------- behavioural model helpers ----------------
    function automatic int nBytes(input logic [2:0] mode);
        int sz = int'(mode[2:1]);
        return (sz == 0) ? 4 : (sz == 1) ? 2 : (sz == 2) ? 1 : 0;
    endfunction

    function automatic bit mLegal(input logic [2:0] mode, input logic [31:0] addr);
        int nb = nBytes(mode);
        if (nb == 0) return 1'b0;
        return (int'(addr[1:0]) % nb) == 0;
    endfunction

    function automatic logic [3:0] mBe(input logic [2:0] mode, input logic [31:0] addr);
        int m = (1 << nBytes(mode)) - 1;
        return 4'(m << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] mLanes(input logic [2:0] mode, input logic [31:0] wd);
        logic [31:0] r;
        int nb = nBytes(mode);
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % nb)*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mExt(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] rd);
        int nb = nBytes(mode);
        logic [31:0] v = rd >> (int'(addr[1:0]) * 8);
        logic [31:0] mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (nb * 8)) - 32'd1);
        v = v & mask;
        if (nb < 4 && mode[0] && v[nb*8-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearExp();
        eStall = 1'b0; eAlign = 1'b0; eBerr = 1'b0; eReq = 1'b0; eLdv = 1'b0;
        busChk = 1'b0; eAddr = 32'd0; eBe = 4'd0; eWe = 1'b0; eWdata = 32'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            op_valid = 1'b0;
            bus.bus_ready = 1'b0;
            eStall = 1'b0; eAlign = 1'b0; eBerr = 1'b0; eLdv = 1'b0;
            cycle();
        end
    endtask

    // One op: slave answers after 'waits' idle REQ cycles; resetAt>0
    // asserts reset in that REQ cycle; mayDrop lets op_valid wander in REQ.
    task automatic doOp(input bit we, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        input bit mayDrop, input int resetAt);
        clearExp();
        op_valid = 1'b1; op_we = we; op_mode = mode; op_addr = addr;
        op_wdata = wd; op_pc = $urandom; bus.bus_ready = 1'b0; bus.bus_rdata = $urandom;
        if (!mLegal(mode, addr)) begin
            eAlign = 1'b1;
            cycle();
            op_valid = 1'b0;
            clearExp();
            return;
        end
        eStall = 1'b1;
        cycle();
        eReq = 1'b1; busChk = 1'b1; eWe = we;
        eAddr = {addr[31:2], 2'b00}; eBe = mBe(mode, addr);
        eWdata = we ? mLanes(mode, wd) : 32'd0;
        for (int k = 1; k <= TO; k++) begin
            bus.bus_ready = ((k - 1) == waits);
            bus.bus_rdata = bus.bus_ready ? rd : $urandom;
            if (mayDrop) op_valid = 1'($urandom_range(0, 1));
            if (resetAt == k) begin
                reset = 1'b1;
                eStall = op_valid;
                cycle();
                reset = 1'b0; op_valid = 1'b0; bus.bus_ready = 1'b0;
                clearExp();
                busChk = 1'b1;
                eLd = 32'd0;
                return;
            end
            if (bus.bus_ready) begin
                eStall = op_valid;
                cycle();
                break;
            end
            if (k == TO) begin
                eBerr = 1'b1; eStall = 1'b0;
                cycle();
                op_valid = 1'b0; bus.bus_ready = 1'b0;
                clearExp();
                return;
            end
            eStall = op_valid;
            cycle();
        end
        bus.bus_ready = 1'b0;
        eReq = 1'b0; busChk = 1'b0; eStall = 1'b0; eLdv = !we;
        if (!we) eLd = mExt(mode, addr, rd);
        cycle();
        op_valid = 1'b0;
        clearExp();
    endtask

    initial begin
        chkEn = 1'b0; pinBusEn = 1'b0; pinLdEn = 1'b0;
        pinAddr = 32'd0; pinBe = 4'd0; pinWdata = 32'd0; pinLd = 32'd0; pinLdT = 0;
        reset = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_mode = 3'd0;
        op_addr = 32'd0; op_wdata = 32'd0; op_pc = 32'd0;
        bus.bus_ready = 1'b0; bus.bus_rdata = 32'd0;
        clearExp();
        eLd = 32'd0;
        cycle();
        chkEn = 1'b1; busChk = 1'b1;
        cycle();
        reset = 1'b0;
        idle(2);

        // SW 0x10, zero-wait slave.
        pinBusEn = 1'b1; pinAddr = 32'h10; pinBe = 4'b1111; pinWdata = 32'hDEADBEEF;
        doOp(1'b1, 3'b000, 32'h10, 32'hDEADBEEF, 32'd0, 0, 1'b0, 0);
        idle(1);
        // SB 0x13.
        pinAddr = 32'h10; pinBe = 4'b1000; pinWdata = 32'hA5A5A5A5;
        doOp(1'b1, 3'b100, 32'h13, 32'h000000A5, 32'd0, 1, 1'b0, 0);
        pinBusEn = 1'b0;
        idle(1);
        // LH signed 0x22, three wait cycles: ld_valid at t5.
        pinLdEn = 1'b1; pinLd = 32'hFFFF8001; pinLdT = cycleCnt + 5;
        doOp(1'b0, 3'b011, 32'h22, 32'd0, 32'h80011234, 3, 1'b0, 0);
        idle(1);
        // LBU 0x21, zero-wait: ld_valid at t2.
        pinLd = 32'h00000012; pinLdT = cycleCnt + 2;
        doOp(1'b0, 3'b100, 32'h21, 32'd0, 32'h80011234, 0, 1'b0, 0);
        pinLdEn = 1'b0;
        idle(1);
        // Misaligned word and illegal size.
        doOp(1'b0, 3'b000, 32'h06, 32'd0, 32'd0, 0, 1'b0, 0);
        idle(1);
        doOp(1'b0, 3'b110, 32'h40, 32'd0, 32'd0, 0, 1'b0, 0);
        idle(1);
        // Timeout, then a fresh LW completes.
        doOp(1'b0, 3'b000, 32'h80, 32'd0, 32'd0, 20, 1'b0, 0);
        idle(1);
        doOp(1'b0, 3'b000, 32'h84, 32'd0, 32'h13572468, 1, 1'b0, 0);
        idle(1);
        // Reset in the second REQ cycle.
        doOp(1'b0, 3'b000, 32'h88, 32'd0, 32'h11112222, 20, 1'b0, 2);
        idle(2);

        // Randomized ops.
        for (int n = 0; n < 300; n++) begin
            int rAt;
            rAt = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0;
            doOp(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                 $urandom, int'($urandom_range(0, 5)), 1'($urandom_range(0, 3) == 0), rAt);
            idle(int'($urandom_range(0, 2)));
        end
        idle(2);
        chkEn = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
        $finish;
    end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- MEM-stage load/store initiator for the multi-cycle data memory bus in the pipelined MIPS core.
- Accepts one load/store op from the pipeline and checks alignment.
- Issues one word-aligned bus request with byte enables and lane-replicated write data, then waits for slave ready.
- Extracts and sign/zero-extends load data; stalls the pipeline until the access completes.

Parameters:
- TIMEOUT, 255: max cycles in REQ waiting for bus_ready before bus_err; 0 disables timeout.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op_valid  in  1  MEM stage holds a load/store
- op_we  in  1  1=store, 0=load
- op_mode  in  3  [2:1] size: 0=word, 1=half, 2=byte, 3=illegal; [0]=sign-extend (loads only)
- op_addr  in  ADDR_W  byte address
- op_wdata  in  32  store data, low-aligned
- op_pc  in  32  PC of the op (trace only)
- stall  out  1  freeze pipeline upstream of MEM
- ld_valid  out  1  one-cycle pulse, ld_data valid
- ld_data  out  32  extended load result
- align_err  out  1  one-cycle pulse, misaligned or illegal op
- bus_err  out  1  one-cycle pulse, timeout
- bus_req  out  1  request, registered
- bus_we  out  1  write
- bus_addr  out  ADDR_W  {op_addr[ADDR_W-1:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  store data replicated to lanes
- bus_ready  in  1  slave completes the request this cycle
- bus_rdata  in  32  read word, valid with bus_ready

Behaviour:
- States: IDLE, REQ, DONE.
- Reset: state=IDLE. bus_req, bus_we, bus_be, bus_addr, bus_wdata, ld_data, timeout counter all 0. ld_valid, align_err, bus_err 0.
- Alignment check (combinational in IDLE):
  - Illegal when size==3, or word with addr[1:0]!=0, or half with addr[0]!=0.
  - If illegal: align_err=1 for that cycle, stall=0, no bus activity, state stays IDLE.
- Accept: IDLE & op_valid & legal.
  - Register bus_* on that edge; next state REQ.
- Byte enables:
  - word: 4'b1111
  - half: addr[1] ? 4'b1100 : 4'b0011
  - byte: 4'b0001 << addr[1:0]
- Write data lanes:
  - word: wdata
  - half: {2{wdata[15:0]}}
  - byte: {4{wdata[7:0]}}
  - Loads: bus_wdata=0, bus_we=0.
- REQ state:
  - bus_req held high with constant addr/be/wdata until bus_ready is sampled 1.
  - On bus_ready: for loads, latch extracted data into ld_data (selected lane, sign- or zero-extended per op_mode[0]). Then bus_req=0 and next state DONE.
- DONE state (1 cycle):
  - ld_valid=1 for loads, 0 for stores; stall=0; next state IDLE.
- Stall: op_valid & legal & state!=DONE. The pipeline advances only on the DONE cycle or the align_err cycle.
- Latency: zero-wait slave (ready the first REQ cycle) gives accept at t0, REQ at t1, DONE at t2. Each wait cycle adds 1.
- Timeout: counter increments every REQ cycle without ready.
  - When it reaches TIMEOUT: bus_err=1, bus_req=0 on the next edge, state returns to IDLE, no ld_valid.
  - stall=0 in the bus_err cycle.
- Same-cycle ready and timeout: ready wins.
- Reset mid-transaction: next edge forces IDLE and bus_req=0. The slave must tolerate an abandoned request; no ld_valid or error pulse is issued.
- op_valid dropping while in REQ: the transaction still completes and results are discarded by the pipeline (flush-safe).

Optional Feature:
- Macro LSU_TRACE_EN.
- Defined: on each store completion (REQ & bus_ready & bus_we), $display "%d@%08h: *%08h <= %08h be=%b" with $time, op_pc, bus_addr, bus_wdata, bus_be.
- Undefined: no display code, identical logic.

Decomposition:
- Package lsu_pkg: size codes (SZ_WORD=0, SZ_HALF=1, SZ_BYTE=2), state enum (IDLE/REQ/DONE), BE constants.
- Sub-module lsu_lane_unit: combinational be/wdata generation plus load extraction/extension. Instantiated once; the FSM, counter and registers stay in the top.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF, ready at first REQ cycle -> bus_be=1111, bus_addr=0x10, stall high 2 cycles, DONE at t2, no ld_valid.
- SB addr 0x13, wdata 0x000000A5 -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x10.
- LH signed addr 0x22, rdata 0x8001_1234, ready after 3 waits -> ld_data=0xFFFF8001, ld_valid at t5. LBU addr 0x21 same rdata -> 0x00000012.
- LW addr 0x06 -> align_err pulse, bus_req never rises, stall=0. Same for size=3.
- TIMEOUT=4, ready held low -> bus_err on 4th REQ cycle, IDLE next, no ld_valid. Then a fresh LW completes normally.
- reset asserted in 2nd REQ cycle -> bus_req=0 next edge, state IDLE, all pulses 0.
